// File: rtl/xy_input_unit.sv
// Router input unit: 4-deep flit FIFO, XY route decode of head flits, and a
// wormhole-held one-hot request toward the selected output arbiter.
module xy_input_unit #(
    parameter int DATA_WIDTH     = 8,
    parameter int ROW_ADDR_W     = 2,
    parameter int COL_ADDR_W     = 2,
    parameter int ROW_CORD       = 0,
    parameter int COL_CORD       = 0,
    parameter int BUFFER_DEPTH_W = 2,
    parameter int OUT_N          = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH+1:0] data_i,
    input  logic                  wr_en_i,
    output logic                  rdy_o,
    output logic [DATA_WIDTH+1:0] data_o,
    output logic [OUT_N-1:0]      out_req_o,
    input  logic                  rd_en_i,
    output logic                  err_o
);

    // state  | meaning
    // IDLE   | waiting for a head at the FIFO front; stray body/tail flits dropped
    // ACTIVE | route latched, request raised while flits are buffered, until tail pop

    localparam int FLIT_W = DATA_WIDTH + 2;
    localparam int DEPTH  = 1 << BUFFER_DEPTH_W;
    localparam int CNT_W  = BUFFER_DEPTH_W + 1;

    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(DEPTH);
    localparam logic [BUFFER_DEPTH_W-1:0] PTR_ONE  = BUFFER_DEPTH_W'(1);
    localparam logic [ROW_ADDR_W-1:0]     ROW_C    = ROW_ADDR_W'(ROW_CORD);
    localparam logic [COL_ADDR_W-1:0]     COL_C    = COL_ADDR_W'(COL_CORD);

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                    state_q, state_d;
    logic [FLIT_W-1:0]         mem [DEPTH];
    logic [BUFFER_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [OUT_N-1:0]          route_q, route_d, route_dec;
    logic                      err_q, err_d;
    logic                      empty, full, push, pop;
    logic [FLIT_W-1:0]         front;
    logic                      front_is_head, front_is_tail;
    logic [COL_ADDR_W-1:0]     col_dst;
    logic [ROW_ADDR_W-1:0]     row_dst;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign push  = wr_en_i && !full;
    assign front = mem[rd_ptr_q];

    // Type bit 1 marks a head (HEAD/HEAD_TAIL), bit 0 a tail (TAIL/HEAD_TAIL)
    assign front_is_head = front[FLIT_W-1];
    assign front_is_tail = front[FLIT_W-2];
    assign col_dst       = front[COL_ADDR_W-1:0];
    assign row_dst       = front[COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W];

    assign rdy_o  = !full;
    assign data_o = front;
    assign err_o  = err_q;

    always_comb begin
        route_dec = '0;
        if (col_dst > COL_C)       route_dec[PORT_E] = 1'b1;
        else if (col_dst < COL_C)  route_dec[PORT_W] = 1'b1;
        else if (row_dst > ROW_C)  route_dec[PORT_S] = 1'b1;
        else if (row_dst < ROW_C)  route_dec[PORT_N] = 1'b1;
        else                       route_dec[PORT_L] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            route_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            route_q <= route_d;
            err_q   <= err_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && front_is_head) state_d = ACTIVE;
            ACTIVE:  if (rd_en_i && !empty && front_is_tail) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs; a mid-packet head is popped like any body flit
    always_comb begin
        pop       = 1'b0;
        err_d     = 1'b0;
        route_d   = route_q;
        out_req_o = '0;
        case (state_q)
            IDLE: begin
                if (!empty && front_is_head) begin
                    route_d = route_dec;
                end else if (!empty) begin
                    pop   = 1'b1;
                    err_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (!empty) out_req_o = route_q;
                pop = rd_en_i && !empty;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xy_input_unit.sv
// Bench for xy_input_unit at router (1,1): directed scenarios plus random
// traffic, all checked against a queue-based packet-level reference model.
module tb_xy_input_unit;

    localparam int FW = 10;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [FW-1:0] data_i;
    logic          wr_en_i;
    logic          rdy_o;
    logic [FW-1:0] data_o;
    logic [4:0]    out_req_o;
    logic          rd_en_i;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [FW-1:0] q[$];
    bit            m_active;
    logic [4:0]    m_route;
    bit            m_err;

    xy_input_unit #(
        .DATA_WIDTH(8), .ROW_ADDR_W(2), .COL_ADDR_W(2),
        .ROW_CORD(1), .COL_CORD(1), .BUFFER_DEPTH_W(2), .OUT_N(5)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .wr_en_i(wr_en_i),
        .rdy_o(rdy_o), .data_o(data_o), .out_req_o(out_req_o),
        .rd_en_i(rd_en_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] ty, input int row, input int col);
        logic [3:0] hi;
        hi = 4'($urandom_range(0, 15));
        return {ty, hi, 2'(row), 2'(col)};
    endfunction

    // XY routing for a router at row 1, column 1
    function automatic logic [4:0] xy_ref(input logic [FW-1:0] f);
        int col, row, port;
        col = int'(f[1:0]);
        row = int'(f[3:2]);
        if (col > 1)      port = 2;
        else if (col < 1) port = 4;
        else if (row > 1) port = 3;
        else if (row < 1) port = 1;
        else              port = 0;
        return 5'(1 << port);
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_route  = '0;
        m_err    = 0;
    endtask

    task automatic model_edge(input logic w, input logic [FW-1:0] d, input logic r);
        bit wr_ok;
        logic [FW-1:0] f;
        wr_ok = w && (q.size() < 4);
        m_err = 0;
        if (q.size() > 0) begin
            if (!m_active) begin
                if (q[0][FW-1]) begin
                    m_active = 1;
                    m_route  = xy_ref(q[0]);
                end else begin
                    void'(q.pop_front());
                    m_err = 1;
                end
            end else if (r) begin
                f = q.pop_front();
                if (f[FW-2]) m_active = 0;
            end
        end
        if (wr_ok) q.push_back(d);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".rdy"}, 32'(rdy_o), 32'(q.size() < 4));
        chk({tag, ".req"}, 32'(out_req_o), (m_active && q.size() > 0) ? 32'(m_route) : 32'd0);
        chk({tag, ".err"}, 32'(err_o), 32'(m_err));
        if (q.size() > 0) chk({tag, ".data"}, 32'(data_o), 32'(q[0]));
    endtask

    // called just after a falling edge; returns just after the next falling edge
    task automatic tick(input string tag, input logic w, input logic [FW-1:0] d, input logic r);
        wr_en_i = w;
        data_i  = d;
        rd_en_i = r;
        @(posedge clk_i);
        model_edge(w, d, r);
        @(negedge clk_i);
        compare_all(tag);
    endtask

    logic [FW-1:0] fill [5];
    int            sweep_rc [4][2] = '{'{1, 1}, '{0, 1}, '{2, 1}, '{1, 0}};
    logic [4:0]    sweep_req [4]   = '{5'b00001, 5'b00010, 5'b01000, 5'b10000};

    initial begin
        rst_ni  = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        data_i  = '0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst.rdy", 32'(rdy_o), 32'd1);
        chk("rst.req", 32'(out_req_o), 32'd0);
        chk("rst.err", 32'(err_o), 32'd0);
        rst_ni = 1'b1;

        // head to (row 1, col 3) goes east; request appears two cycles after write
        tick("hd0", 1, mk(2'b10, 1, 3), 0);
        chk("lat.t", 32'(out_req_o), 32'd0);
        tick("hd1", 0, '0, 0);
        chk("lat.t2", 32'(out_req_o), 32'b00100);
        tick("bd", 1, mk(2'b00, 0, 0), 1);
        tick("tl", 1, mk(2'b01, 0, 0), 1);
        tick("pop3", 0, '0, 1);
        chk("tail.req", 32'(out_req_o), 32'd0);
        chk("tail.idle", 32'(m_active), 32'd0);

        for (int i = 0; i < 4; i++) begin
            tick("sw.w", 1, mk(2'b11, sweep_rc[i][0], sweep_rc[i][1]), 0);
            tick("sw.l", 0, '0, 0);
            chk("sweep.req", 32'(out_req_o), 32'(sweep_req[i]));
            tick("sw.p", 0, '0, 1);
            chk("sweep.drop", 32'(out_req_o), 32'd0);
        end

        // fill: five writes with no reads, fifth discarded
        fill[0] = mk(2'b10, 1, 1);
        fill[1] = mk(2'b00, 0, 0);
        fill[2] = mk(2'b00, 0, 0);
        fill[3] = mk(2'b01, 0, 0);
        fill[4] = mk(2'b00, 2, 2);
        for (int i = 0; i < 5; i++) begin
            tick("fill", 1, fill[i], 0);
            if (i == 3) chk("fill.rdy4", 32'(rdy_o), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("fill.data", 32'(data_o), 32'(fill[i]));
            tick("drain", 0, '0, 1);
            chk("fill.noerr", 32'(err_o), 32'd0);
        end

        // full with simultaneous read and write
        tick("fw0", 1, mk(2'b10, 0, 2), 0);
        for (int i = 0; i < 3; i++) tick("fwb", 1, mk(2'b00, 0, 0), 0);
        chk("full.rdy", 32'(rdy_o), 32'd0);
        tick("fwrw", 1, mk(2'b01, 0, 0), 1);
        chk("full.rdy_after", 32'(rdy_o), 32'd1);
        chk("full.cnt", 32'(q.size()), 32'd3);
        tick("fwt", 1, mk(2'b01, 0, 0), 1);
        repeat (4) tick("fwd", 0, '0, 1);

        // stray body in IDLE
        tick("st.w", 1, mk(2'b00, 3, 3), 0);
        tick("st.d", 0, '0, 0);
        chk("stray.err", 32'(err_o), 32'd1);
        chk("stray.req", 32'(out_req_o), 32'd0);
        tick("st.h", 1, mk(2'b11, 3, 1), 0);
        chk("stray.err_off", 32'(err_o), 32'd0);
        tick("st.l", 0, '0, 0);
        chk("stray.route", 32'(out_req_o), 32'b01000);
        tick("st.p", 0, '0, 1);

        // reset mid-packet with three flits buffered
        tick("rm0", 1, mk(2'b10, 0, 0), 0);
        tick("rm1", 1, mk(2'b00, 0, 0), 0);
        tick("rm2", 1, mk(2'b00, 0, 0), 0);
        chk("rm.req_before", 32'(out_req_o), 32'b10000);
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rm.req", 32'(out_req_o), 32'd0);
        chk("rm.rdy", 32'(rdy_o), 32'd1);
        chk("rm.err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        tick("pr.w", 1, mk(2'b11, 1, 2), 0);
        tick("pr.l", 0, '0, 0);
        chk("rm.newroute", 32'(out_req_o), 32'b00100);
        tick("pr.p", 0, '0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick("rnd", logic'($urandom_range(0, 99) < 60),
                 mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                 logic'($urandom_range(0, 99) < 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
